// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with glitch-free ratio change and stop
//
// Purpose: divides I_CLK by 2*(HALF+1) to a registered square wave. HALF comes from one of
// two presets or a custom value. Ratio changes and stops only take effect at half-period
// boundaries, so O_CLK never has a truncated phase.
//
// Ports:
//   I_CLK    in   sole clock, rising edge
//   I_RST_N  in   synchronous active-low reset
//   I_EN     in   run enable for the divided clock
//   I_REQ    in   ratio-change request (level, sampled each cycle)
//   I_SEL    in   [1:0] ratio source: 00 slow preset, 01 fast preset, 10 I_DIV, 11 invalid
//   I_DIV    in   [CW-1:0] custom half-period terminal count
//   O_CLK    out  divided square wave
//   O_TICK   out  one-cycle pulse in the cycle O_CLK toggles
//   O_ACK    out  one-cycle pulse when a requested ratio takes effect
//   O_ERR    out  one-cycle pulse when a request is rejected
//   O_BUSY   out  high while a ratio change is pending

module clk_div_ctrl #(
  parameter int SLOW_HALF = 25_000_000,
  parameter int FAST_HALF = 1000,
  parameter int CW        = 32
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_EN,
  input  logic          I_REQ,
  input  logic [1:0]    I_SEL,
  input  logic [CW-1:0] I_DIV,
  output logic          O_CLK,
  output logic          O_TICK,
  output logic          O_ACK,
  output logic          O_ERR,
  output logic          O_BUSY
);

  localparam logic [CW-1:0] SLOW_V = CW'(SLOW_HALF);
  localparam logic [CW-1:0] FAST_V = CW'(FAST_HALF);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_PEND,
    ST_DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] half;
  logic [CW-1:0] next_half;
  logic [CW-1:0] count;
  logic          clk_q;
  logic          tick_q;
  logic          ack_q;
  logic          err_q;
  logic          busy_q;

  logic          at_bnd;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] sel_val;
  logic          req_valid;

  always_comb begin
    at_bnd  = (count == half);
    cnt_nxt = at_bnd ? '0 : count + CW'(1);
    case (I_SEL)
      2'b00:   sel_val = SLOW_V;
      2'b01:   sel_val = FAST_V;
      default: sel_val = I_DIV;
    endcase
    // A custom count of 0 would make a divide-by-2 that cannot be stopped
    // cleanly mid-phase, so it is rejected along with the unused encoding.
    req_valid = (I_SEL == 2'b00) || (I_SEL == 2'b01) ||
                ((I_SEL == 2'b10) && (I_DIV != '0));
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state     <= ST_STOP;
      half      <= SLOW_V;
      next_half <= SLOW_V;
      count     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_STOP: begin
          count <= '0;
          clk_q <= 1'b0;
          // Ratio is applied on this edge, so a simultaneous enable counts
          // with the new HALF from the very first cycle.
          if (I_REQ) begin
            if (req_valid) begin
              half  <= sel_val;
              ack_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (I_EN) state <= ST_RUN;
        end

        ST_RUN: begin
          if (!I_EN) begin
            // Disable wins over any request presented on the same edge.
            if (!clk_q) begin
              state <= ST_STOP;
              count <= '0;
            end else if (at_bnd) begin
              // High phase completes on this very edge: fall and stop.
              clk_q  <= 1'b0;
              tick_q <= 1'b1;
              count  <= '0;
              state  <= ST_STOP;
            end else begin
              count <= cnt_nxt;
              state <= ST_DRAIN;
            end
          end else begin
            count <= cnt_nxt;
            if (at_bnd) begin
              clk_q  <= ~clk_q;
              tick_q <= 1'b1;
            end
            if (I_REQ) begin
              if (req_valid) begin
                next_half <= sel_val;
                busy_q    <= 1'b1;
                state     <= ST_PEND;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end

        ST_PEND: begin
          // Requests and enable changes are not looked at here; the swap
          // happens at COUNT==HALF so COUNT restarts at 0 under the new HALF.
          count <= cnt_nxt;
          if (at_bnd) begin
            clk_q  <= ~clk_q;
            tick_q <= 1'b1;
            half   <= next_half;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_RUN;
          end
        end

        ST_DRAIN: begin
          // Only entered with O_CLK high, so the next boundary is the fall.
          count <= cnt_nxt;
          if (at_bnd) begin
            clk_q  <= 1'b0;
            tick_q <= 1'b1;
            state  <= ST_STOP;
          end
        end

        default: begin
          state <= ST_STOP;
          count <= '0;
          clk_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_CLK  = clk_q;
  assign O_TICK = tick_q;
  assign O_ACK  = ack_q;
  assign O_ERR  = err_q;
  assign O_BUSY = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl

module tb_clk_div_ctrl;

  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          req;
  logic [1:0]    sel;
  logic [CW-1:0] div;
  logic          o_clk;
  logic          o_tick;
  logic          o_ack;
  logic          o_err;
  logic          o_busy;

  int vectors;
  int miscompares;

  clk_div_ctrl #(
    .SLOW_HALF(9),
    .FAST_HALF(3),
    .CW(CW)
  ) dut (
    .I_CLK  (clk),
    .I_RST_N(rst_n),
    .I_EN   (en),
    .I_REQ  (req),
    .I_SEL  (sel),
    .I_DIV  (div),
    .O_CLK  (o_clk),
    .O_TICK (o_tick),
    .O_ACK  (o_ack),
    .O_ERR  (o_err),
    .O_BUSY (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 1'b0;
    sel   = 2'b00;
    div   = '0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Packs {clk, tick, ack, err, busy} so one comparison covers a whole cycle.
  task automatic chk(input string name, input int idx, input logic [4:0] exp);
    logic [4:0] act;
    act = {o_clk, o_tick, o_ack, o_err, o_busy};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: {clk,tick,ack,err,busy} got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({o_clk, o_tick, o_ack, o_err, o_busy} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 00000", {o_clk, o_tick, o_ack, o_err, o_busy});
    end
    cycle();
    vectors++;
    if (o_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_idle_clk: got %b expected 0", o_clk);
    end
  endtask

  task automatic test_slow_run();
    logic exp_clk;
    logic exp_tick;
    en = 1'b1;
    cycle();
    for (int k = 1; k <= 40; k++) begin
      cycle();
      exp_clk  = ((k / 10) % 2) == 1;
      exp_tick = (k % 10) == 0;
      if ({o_clk, o_tick, o_ack, o_err, o_busy} !== {exp_clk, exp_tick, 3'b000}) begin
        miscompares++;
        $display("FAIL slow_run[%0d]: got %b expected %b", k,
                 {o_clk, o_tick, o_ack, o_err, o_busy}, {exp_clk, exp_tick, 3'b000});
      end
      vectors++;
    end
  endtask

  task automatic test_fast_switch();
    logic exp_clk;
    logic exp_tick;
    cycle();
    cycle();
    req = 1'b1;
    sel = 2'b01;
    cycle();
    chk("pend_enter", 0, 5'b00001);
    // Invalid requests held during PEND must be silently ignored.
    sel = 2'b11;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("pend_hold", i, 5'b00001);
    end
    req = 1'b0;
    cycle();
    vectors++;
    if ({o_clk, o_tick, o_ack, o_err, o_busy} !== 5'b11100) begin
      miscompares++;
      $display("FAIL pend_apply: got %b expected 11100", {o_clk, o_tick, o_ack, o_err, o_busy});
    end
    for (int j = 1; j <= 12; j++) begin
      cycle();
      exp_clk  = ~(((j / 4) % 2) == 1);
      exp_tick = (j % 4) == 0;
      chk("fast_run", j, {exp_clk, exp_tick, 3'b000});
    end
  endtask

  task automatic test_invalid();
    logic exp_clk;
    logic exp_tick;
    logic exp_err;
    for (int j = 1; j <= 12; j++) begin
      req = (j == 1) || (j == 2);
      sel = (j == 1) ? 2'b11 : 2'b10;
      div = '0;
      cycle();
      exp_clk  = ((j / 4) % 2) == 1;
      exp_tick = (j % 4) == 0;
      exp_err  = (j == 1) || (j == 2);
      chk("invalid_run", j, {exp_clk, exp_tick, 1'b0, exp_err, 1'b0});
    end
    req = 1'b0;
  endtask

  task automatic test_stop_req();
    do_reset();
    req = 1'b1;
    sel = 2'b11;
    cycle();
    chk("stop_invalid", 0, 5'b00010);
    sel = 2'b01;
    cycle();
    chk("stop_valid", 0, 5'b00100);
    req = 1'b0;
    cycle();
    chk("stop_stays", 0, 5'b00000);
    en = 1'b1;
    cycle();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("stop_req_fast", k, {((k / 4) % 2) == 1, (k % 4) == 0, 3'b000});
    end
  endtask

  task automatic test_drain();
    do_reset();
    en = 1'b1;
    cycle();
    for (int k = 1; k <= 14; k++) cycle();
    chk("drain_pre", 0, 5'b10000);
    en = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      cycle();
      if (j <= 5)       chk("drain", j, 5'b10000);
      else if (j == 6)  chk("drain", j, 5'b01000);
      else              chk("drain", j, 5'b00000);
    end
  endtask

  task automatic test_reset_pend();
    do_reset();
    en = 1'b1;
    cycle();
    for (int k = 1; k <= 12; k++) cycle();
    req = 1'b1;
    sel = 2'b01;
    cycle();
    req = 1'b0;
    chk("rp_pend", 0, 5'b10001);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rp_reset", 0, 5'b00000);
    rst_n = 1'b1;
    en    = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      cycle();
      chk("rp_slow", k, {k == 10, k == 10, 3'b000});
    end
  endtask

  task automatic test_stop_custom();
    do_reset();
    cycle();
    req = 1'b1;
    sel = 2'b10;
    div = 8'd1;
    en  = 1'b1;
    cycle();
    req = 1'b0;
    chk("custom_ack", 0, 5'b00100);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("custom_run", k, {((k / 2) % 2) == 1, (k % 2) == 0, 3'b000});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 1'b0;
    sel   = 2'b00;
    div   = '0;
    test_reset();
    test_slow_run();
    test_fast_switch();
    test_invalid();
    test_stop_req();
    test_drain();
    test_reset_pend();
    test_stop_custom();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
